// File: rtl/out_pix_feeder.sv
// out_pix_feeder: filters processor stores into an output pixel window,
// saturates them to 8 bits and paces them out to the output memory stage.
//
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   start        one-cycle pulse arming a new frame (ignored while running)
//   st_valid     store request from the processor
//   st_addr      store address (one pixel per address)
//   st_data      signed store data
//   st_ready     store accepted when st_valid && st_ready
//   out_result   {24'b0, pixel}, held between pops
//   out_enable   one-cycle write strobe, never high two cycles in a row
//   pix_count    pixels emitted this frame, saturating at NUM_PIX
//   frame_done   level, set on entry to DONE, cleared by start or rst
//   order_err    sticky out-of-order window store flag
module out_pix_feeder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          NUM_PIX    = 11,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic [31:0] out_result,
    output logic        out_enable,
    output logic [7:0]  pix_count,
    output logic        frame_done,
    output logic        order_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0] NUM_PIX_C = 8'(NUM_PIX);
    localparam logic [31:0] WIN_END = BASE_ADDR + 32'(NUM_PIX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       pix_cnt_q, pix_cnt_d;
    logic [31:0]      result_q, result_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic        run;
    logic        enter_run;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        win_hit;
    logic        in_order;
    logic        push;
    logic        pop;
    logic        bypass;
    logic        fifo_wr;
    logic        fifo_rd;
    logic [31:0] exp_addr;
    logic [7:0]  pix_sat;
    logic [7:0]  pop_pix;

    assign run        = (state_q == RUN);
    assign enter_run  = start && !run;
    assign fifo_full  = (cnt_q == DEPTH_C);
    assign fifo_empty = (cnt_q == '0);
    assign exp_addr   = BASE_ADDR + {24'b0, idx_q};
    assign win_hit    = (st_addr >= BASE_ADDR) && (st_addr < WIN_END);
    assign in_order   = (st_addr == exp_addr);
    assign accept     = st_valid && st_ready;

    // Once idx_q reaches NUM_PIX the expected address lies outside the
    // window, so no further pixel can be pushed this frame.
    assign push = accept && run && win_hit && in_order;

    // A push into an empty FIFO while the strobe is low goes straight to
    // the output register, giving one cycle of latency.
    assign pop     = run && !en_q && (!fifo_empty || push);
    assign bypass  = push && pop && fifo_empty;
    assign fifo_wr = push && !bypass;
    assign fifo_rd = pop && !fifo_empty;

    always_comb begin
        if (st_data[31]) begin
            pix_sat = 8'd0;
        end else if (st_data[30:8] != '0) begin
            pix_sat = 8'd255;
        end else begin
            pix_sat = st_data[7:0];
        end
    end

    assign pop_pix = fifo_empty ? pix_sat : fifo_q[rd_ptr_q];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (pix_cnt_q == NUM_PIX_C) state_d = DONE;
            DONE: if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: st_ready depends only on registered state
    always_comb begin
        st_ready = 1'b1;
        if (run) begin
            st_ready = !fifo_full;
        end
    end

    // Datapath next-state
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pix_cnt_d = pix_cnt_q;
        result_d  = result_q;
        en_d      = 1'b0;
        done_d    = done_q;
        err_d     = err_q;

        if (fifo_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (fifo_rd) rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({fifo_wr, fifo_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (push) idx_d = idx_q + 8'd1;

        if (accept && run && win_hit && !in_order) err_d = 1'b1;

        if (pop) begin
            result_d = {24'b0, pop_pix};
            en_d     = 1'b1;
            if (pix_cnt_q != NUM_PIX_C) pix_cnt_d = pix_cnt_q + 8'd1;
        end

        if (run && (state_d == DONE)) done_d = 1'b1;

        if (enter_run) begin
            idx_d     = '0;
            pix_cnt_d = '0;
            err_d     = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            pix_cnt_q <= '0;
            result_q  <= '0;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pix_cnt_q <= pix_cnt_d;
            result_q  <= result_d;
            en_q      <= en_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset: occupancy is reset instead.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_q[wr_ptr_q] <= pix_sat;
        end
    end

    assign out_result = result_q;
    assign out_enable = en_q;
    assign pix_count  = pix_cnt_q;
    assign frame_done = done_q;
    assign order_err  = err_q;

endmodule

// File: tb/tb_out_pix_feeder.sv
// Self-checking bench for out_pix_feeder.
// Scenario tasks against a queue-based reference model.
module tb_out_pix_feeder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          NPIX  = 11;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic [31:0] out_result;
    logic        out_enable;
    logic [7:0]  pix_count;
    logic        frame_done;
    logic        order_err;

    always #5 clk = ~clk;

    out_pix_feeder #(
        .BASE_ADDR (BASE),
        .NUM_PIX   (NPIX),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .out_result(out_result),
        .out_enable(out_enable),
        .pix_count (pix_count),
        .frame_done(frame_done),
        .order_err (order_err)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int   consec    = 0;
    int   ready_low = 0;
    int   hi_bad    = 0;
    logic prev_en   = 1'b0;

    bit m_run = 1'b0;
    int m_idx = 0;
    bit m_err = 1'b0;

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (out_enable === 1'b1) begin
            obs_q.push_back(out_result[7:0]);
            if (out_result[31:8] !== 24'b0) hi_bad++;
        end
        if (out_enable === 1'b1 && prev_en === 1'b1) consec++;
        if (st_ready === 1'b0) ready_low++;
        prev_en = out_enable;
    end

    function automatic logic [7:0] sat_ref(input logic [31:0] d);
        int v;
        v = $signed(d);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    function automatic void model_accept(input logic [31:0] a,
                                         input logic [31:0] d);
        if (m_run && a >= BASE && a < BASE + 32'(NPIX)) begin
            if (a == BASE + 32'(m_idx)) begin
                exp_q.push_back(sat_ref(d));
                m_idx++;
            end else begin
                m_err = 1'b1;
            end
        end
    endfunction

    // Called at a negedge; returns at a negedge with st_valid low.
    task automatic send(input logic [31:0] a, input logic [31:0] d);
        int w;
        w = 0;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        while (st_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        cmp_cnt++;
        if (st_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL send_timeout: st_ready=%0b required 1", st_ready);
        end else begin
            @(posedge clk);
            model_accept(a, d);
            @(negedge clk);
        end
        st_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
        if (m_idx == NPIX) m_run = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (!m_run) begin
            m_run = 1'b1;
            m_idx = 0;
            m_err = 1'b0;
        end
    endtask

    task automatic fresh_frame();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_run = 1'b0;
        obs_q.delete();
        exp_q.delete();
        consec    = 0;
        ready_low = 0;
        hi_bad    = 0;
        pulse_start();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        st_valid = 1'b1;
        st_addr  = BASE;
        st_data  = 32'd7;
        repeat (2) @(negedge clk);
        cmp_cnt++;
        if (out_enable !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_out_enable: got %0b want 0", out_enable);
        end
        cmp_cnt++;
        if (out_result !== 32'd0) begin
            err_cnt++;
            $display("FAIL rst_out_result: got %0h want 0", out_result);
        end
        cmp_cnt++;
        if (pix_count !== 8'd0) begin
            err_cnt++;
            $display("FAIL rst_pix_count: got %0d want 0", pix_count);
        end
        cmp_cnt++;
        if (frame_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_frame_done: got %0b want 0", frame_done);
        end
        cmp_cnt++;
        if (order_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_order_err: got %0b want 0", order_err);
        end
        cmp_cnt++;
        if (st_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_st_ready: got %0b want 1", st_ready);
        end
        start    = 1'b0;
        st_valid = 1'b0;
        rst      = 1'b0;
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if (out_enable !== 1'b0 || obs_q.size() != 0) begin
            err_cnt++;
            $display("FAIL idle_no_pulse: got %0d pulses want 0",
                     obs_q.size());
        end
    endtask

    task automatic test_inorder();
        obs_q.delete();
        exp_q.delete();
        consec = 0;
        pulse_start();
        for (int i = 0; i < NPIX; i++) send(BASE + 32'(i), 32'(i));
        drain(20);
        cmp_cnt++;
        if (obs_q.size() != NPIX) begin
            err_cnt++;
            $display("FAIL inorder_count: got %0d want %0d",
                     obs_q.size(), NPIX);
        end
        for (int i = 0; i < NPIX; i++) begin
            cmp_cnt++;
            if (i >= obs_q.size() || obs_q[i] !== 8'(i)) begin
                err_cnt++;
                $display("FAIL inorder_pix%0d: got %0h want %0h", i,
                         (i < obs_q.size()) ? obs_q[i] : 8'hxx, 8'(i));
            end
        end
        cmp_cnt++;
        if (pix_count !== 8'(NPIX)) begin
            err_cnt++;
            $display("FAIL inorder_pix_count: got %0d want %0d",
                     pix_count, NPIX);
        end
        cmp_cnt++;
        if (frame_done !== 1'b1) begin
            err_cnt++;
            $display("FAIL inorder_frame_done: got %0b want 1", frame_done);
        end
        cmp_cnt++;
        if (order_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL inorder_order_err: got %0b want 0", order_err);
        end
        cmp_cnt++;
        if (consec != 0) begin
            err_cnt++;
            $display("FAIL inorder_spacing: got %0d back-to-back want 0",
                     consec);
        end
    endtask

    task automatic test_done();
        logic [7:0] d;
        obs_q.delete();
        exp_q.delete();
        for (int k = 0; k < 3; k++) send(BASE + 32'(k), $urandom);
        drain(6);
        cmp_cnt++;
        if (obs_q.size() != 0) begin
            err_cnt++;
            $display("FAIL done_discard: got %0d pulses want 0",
                     obs_q.size());
        end
        cmp_cnt++;
        if (frame_done !== 1'b1 || pix_count !== 8'(NPIX)) begin
            err_cnt++;
            $display("FAIL done_hold: got done=%0b cnt=%0d want 1/%0d",
                     frame_done, pix_count, NPIX);
        end
        pulse_start();
        cmp_cnt++;
        if (frame_done !== 1'b0 || pix_count !== 8'd0) begin
            err_cnt++;
            $display("FAIL done_restart: got done=%0b cnt=%0d want 0/0",
                     frame_done, pix_count);
        end
        d = 8'($urandom_range(0, 255));
        send(BASE, {24'b0, d});
        cmp_cnt++;
        if (out_enable !== 1'b1 || pix_count !== 8'd1 ||
            out_result !== {24'b0, d}) begin
            err_cnt++;
            $display("FAIL done_first_pix: got en=%0b cnt=%0d res=%0h want 1/1/%0h",
                     out_enable, pix_count, out_result, d);
        end
        drain(4);
    endtask

    task automatic test_latency();
        logic [31:0] d;
        logic [7:0]  p;
        fresh_frame();
        d = $urandom;
        p = sat_ref(d);
        send(BASE, d);
        cmp_cnt++;
        if (out_enable !== 1'b1 || out_result !== {24'b0, p} ||
            pix_count !== 8'd1) begin
            err_cnt++;
            $display("FAIL latency: got en=%0b res=%0h cnt=%0d want 1/%0h/1",
                     out_enable, out_result, pix_count, p);
        end
        @(negedge clk);
        cmp_cnt++;
        if (out_enable !== 1'b0 || out_result !== {24'b0, p}) begin
            err_cnt++;
            $display("FAIL latency_hold: got en=%0b res=%0h want 0/%0h",
                     out_enable, out_result, p);
        end
        drain(4);
    endtask

    task automatic test_saturation();
        logic [7:0] want [3];
        want[0] = 8'd0;
        want[1] = 8'd255;
        want[2] = 8'd255;
        fresh_frame();
        send(BASE, 32'hFFFF_FFFB);
        send(BASE + 32'd1, 32'd300);
        send(BASE + 32'd2, 32'd255);
        drain(10);
        cmp_cnt++;
        if (obs_q.size() != 3) begin
            err_cnt++;
            $display("FAIL sat_count: got %0d want 3", obs_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            cmp_cnt++;
            if (i >= obs_q.size() || obs_q[i] !== want[i]) begin
                err_cnt++;
                $display("FAIL sat_pix%0d: got %0h want %0h", i,
                         (i < obs_q.size()) ? obs_q[i] : 8'hxx, want[i]);
            end
        end
    endtask

    task automatic test_window_order();
        logic [31:0] d;
        fresh_frame();
        send(BASE - 32'd1, 32'd1);
        send(BASE + 32'(NPIX), 32'd2);
        cmp_cnt++;
        if (order_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL window_miss_err: got %0b want 0", order_err);
        end
        send(BASE + 32'd2, 32'd3);
        drain(6);
        cmp_cnt++;
        if (obs_q.size() != 0) begin
            err_cnt++;
            $display("FAIL window_no_pulse: got %0d pulses want 0",
                     obs_q.size());
        end
        cmp_cnt++;
        if (order_err !== m_err || order_err !== 1'b1) begin
            err_cnt++;
            $display("FAIL window_order_err: got %0b want 1", order_err);
        end
        pulse_start();
        cmp_cnt++;
        if (order_err !== 1'b1) begin
            err_cnt++;
            $display("FAIL run_start_ignored: got %0b want 1", order_err);
        end
        d = $urandom;
        send(BASE, d);
        drain(6);
        cmp_cnt++;
        if (obs_q.size() != 1 || obs_q[0] !== sat_ref(d)) begin
            err_cnt++;
            $display("FAIL window_recover: got n=%0d want 1 pixel %0h",
                     obs_q.size(), sat_ref(d));
        end
    endtask

    task automatic test_backpressure();
        fresh_frame();
        for (int i = 0; i < NPIX; i++) send(BASE + 32'(i), $urandom);
        drain(30);
        cmp_cnt++;
        if (ready_low == 0) begin
            err_cnt++;
            $display("FAIL bp_ready_low: got %0d low cycles want >0",
                     ready_low);
        end
        cmp_cnt++;
        if (obs_q.size() != exp_q.size()) begin
            err_cnt++;
            $display("FAIL bp_count: got %0d want %0d",
                     obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            cmp_cnt++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                err_cnt++;
                $display("FAIL bp_pix%0d: got %0h want %0h", i,
                         (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
            end
        end
        cmp_cnt++;
        if (consec != 0) begin
            err_cnt++;
            $display("FAIL bp_spacing: got %0d back-to-back want 0", consec);
        end
    endtask

    task automatic test_reset_midframe();
        fresh_frame();
        for (int i = 0; i < 5; i++) begin
            send(BASE + 32'(i), 32'($urandom_range(0, 255)));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_run = 1'b0;
        cmp_cnt++;
        if (out_enable !== 1'b0 || out_result !== 32'd0 ||
            pix_count !== 8'd0 || frame_done !== 1'b0 ||
            order_err !== 1'b0 || st_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL midrst_outputs: got en=%0b res=%0h cnt=%0d dn=%0b oe=%0b rdy=%0b",
                     out_enable, out_result, pix_count, frame_done,
                     order_err, st_ready);
        end
        repeat (10) @(negedge clk);
        // Back-to-back stores emit on alternate cycles, so three pulses
        // precede the reset edge and the last two pixels are dropped.
        cmp_cnt++;
        if (obs_q.size() != 3) begin
            err_cnt++;
            $display("FAIL midrst_pulses: got %0d want 3", obs_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            cmp_cnt++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                err_cnt++;
                $display("FAIL midrst_pix%0d: got %0h want %0h", i,
                         (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
            end
        end
        test_inorder();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        int          r;
        int          n;
        for (int f = 0; f < 4; f++) begin
            obs_q.delete();
            exp_q.delete();
            consec = 0;
            hi_bad = 0;
            pulse_start();
            n = 0;
            while (m_idx < NPIX && n < 300) begin
                r = $urandom_range(0, 9);
                if (r < 6) a = BASE + 32'(m_idx);
                else if (r == 6) a = BASE - 32'($urandom_range(1, 16));
                else if (r == 7) a = BASE + 32'(NPIX) + 32'($urandom_range(0, 15));
                else a = BASE + 32'($urandom_range(0, NPIX - 1));
                case ($urandom_range(0, 3))
                    0: d = $urandom;
                    1: d = 32'($urandom_range(0, 255));
                    2: d = 32'd0 - 32'($urandom_range(1, 1000));
                    default: d = 32'($urandom_range(256, 100000));
                endcase
                send(a, d);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
                n++;
            end
            drain(40);
            cmp_cnt++;
            if (obs_q.size() != exp_q.size()) begin
                err_cnt++;
                $display("FAIL rnd%0d_count: got %0d want %0d", f,
                         obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                cmp_cnt++;
                if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                    err_cnt++;
                    $display("FAIL rnd%0d_pix%0d: got %0h want %0h", f, i,
                             (i < obs_q.size()) ? obs_q[i] : 8'hxx,
                             exp_q[i]);
                end
            end
            cmp_cnt++;
            if (pix_count !== 8'(exp_q.size()) || frame_done !== 1'b1) begin
                err_cnt++;
                $display("FAIL rnd%0d_status: got cnt=%0d dn=%0b want %0d/1",
                         f, pix_count, frame_done, exp_q.size());
            end
            cmp_cnt++;
            if (order_err !== m_err) begin
                err_cnt++;
                $display("FAIL rnd%0d_order_err: got %0b want %0b", f,
                         order_err, m_err);
            end
            cmp_cnt++;
            if (consec != 0 || hi_bad != 0) begin
                err_cnt++;
                $display("FAIL rnd%0d_strobe: got consec=%0d hibits=%0d want 0/0",
                         f, consec, hi_bad);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        test_reset();
        test_inorder();
        test_done();
        test_latency();
        test_saturation();
        test_window_order();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, err_cnt);
        $finish;
    end

endmodule
